uart_transmitter: RTL

Serialises bytes onto a UART TX line (8 data bits, LSB first, optional parity, 1 or 2 stop bits) in the clk_40 domain. It is the transmit counterpart of uart_receiver and shares its framing and baud constants. A one-entry holding register behind a valid/ready handshake allows back-to-back frames with no idle gap. It will carry status and echo traffic from controller back to the host.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_transmitter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART framing definitions used by both uart_transmitter and
// uart_receiver: transmit FSM state type, data width, idle line level and the
// bit-period calculation.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_tx_state_t;

    // Clock cycles per UART bit, rounded to the nearest integer.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
// Serialises bytes onto a UART TX line: start bit, 8 data bits LSB first,
// optional parity bit, 1 or 2 stop bits. A one-entry holding register behind
// a valid/ready handshake lets the next byte wait during the current frame so
// frames can run back-to-back with no idle gap.
//
// Ports:
//   clock       in   system clock
//   reset       in   asynchronous, active-high reset
//   data[7:0]   in   byte to transmit
//   data_valid  in   data is valid this cycle
//   ready       out  holding register empty; byte accepted on data_valid & ready
//   tx          out  serial line, idle high, driven from a flop
//   busy        out  frame in progress or byte held
//
// State table:
//   ST_IDLE   | line idle, waiting for a held byte
//   ST_START  | driving the start bit (low)
//   ST_DATA   | driving data bit shift_q[idx_q]
//   ST_PARITY | driving the parity bit
//   ST_STOP   | driving stop bit(s) (high); idx_q counts stop bits
// -----------------------------------------------------------------------------
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 40000000,
    parameter int BAUD       = 115200,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       data_valid,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
    localparam int CW    = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int IDX_W = $clog2(UART_DATA_BITS);

    localparam logic [CW-1:0]    CNT_LAST  = CW'(CPB - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(UART_DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic             PAR_EN    = (PARITY_EN != 0);
    localparam logic             PAR_ODD   = (PARITY_ODD != 0);

    generate
        if (CPB < 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_cfg
            $error("uart_transmitter: need CLKS_PER_BIT >= 2 and STOP_BITS in {1,2}");
        end
    endgenerate

    uart_tx_state_t   state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             tx_q, tx_d;

    logic             bit_end;
    logic [IDX_W-1:0] idx_nxt;
    logic             par_bit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_q        <= UART_IDLE_LEVEL;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_q        <= tx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_d        = tx_q;

        bit_end = (cnt_q == CNT_LAST);
        idx_nxt = idx_q + IDX_W'(1);
        // The shifter is indexed, not shifted, so it still holds the whole
        // byte when the parity bit is due.
        par_bit = (^shift_q) ^ PAR_ODD;

        // Accept only into an empty holding register. Loading below requires
        // it full, so accept and load never coincide.
        if (data_valid && !hold_full_q) begin
            hold_d      = data;
            hold_full_d = 1'b1;
        end

        if (state_q != ST_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                tx_d  = UART_IDLE_LEVEL;
                if (hold_full_q) begin
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    tx_d        = 1'b0;
                    state_d     = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (idx_q == DATA_LAST) begin
                        idx_d = '0;
                        if (PAR_EN) begin
                            tx_d    = par_bit;
                            state_d = ST_PARITY;
                        end else begin
                            tx_d    = UART_IDLE_LEVEL;
                            state_d = ST_STOP;
                        end
                    end else begin
                        idx_d = idx_nxt;
                        tx_d  = shift_q[idx_nxt];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    idx_d   = '0;
                    tx_d    = UART_IDLE_LEVEL;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (idx_q == STOP_LAST) begin
                        idx_d = '0;
                        // A held byte starts immediately: zero-gap back-to-back.
                        if (hold_full_q) begin
                            shift_d     = hold_q;
                            hold_full_d = 1'b0;
                            tx_d        = 1'b0;
                            state_d     = ST_START;
                        end else begin
                            tx_d    = UART_IDLE_LEVEL;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d = idx_nxt;
                    end
                end
            end
            default: begin
                tx_d    = UART_IDLE_LEVEL;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign tx    = tx_q;
    assign ready = ~hold_full_q;
    assign busy  = (state_q != ST_IDLE) | hold_full_q;

endmodule
